// File: rtl/sys_cmd_pkg.sv
// Shared command codes, encodings and byte-sequence helpers for the UART
// command frame generator.
package sys_cmd_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned FUNC_W = 4;
  localparam int unsigned TYPE_W = 2;
  localparam int unsigned IDX_W  = 2;

  localparam logic [BYTE_W-1:0] CMD_WR      = 8'hAA;
  localparam logic [BYTE_W-1:0] CMD_RD      = 8'hBB;
  localparam logic [BYTE_W-1:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [BYTE_W-1:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [TYPE_W-1:0] {
    TYPE_WR      = 2'd0,
    TYPE_RD      = 2'd1,
    TYPE_ALU_OP  = 2'd2,
    TYPE_ALU_NOP = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_GAP    = 3'd5
  } ser_state_e;

  typedef struct packed {
    cmd_type_e          cmd_type;
    logic [ADDR_W-1:0]  addr;
    logic [BYTE_W-1:0]  data;
    logic [BYTE_W-1:0]  op_b;
    logic [FUNC_W-1:0]  func;
    logic               par_en;
    logic               par_typ;
  } cmd_req_t;

  // Index of the final byte of each command sequence.
  function automatic logic [IDX_W-1:0] last_idx(input cmd_type_e t);
    case (t)
      TYPE_WR:     last_idx = 2'd2;
      TYPE_RD:     last_idx = 2'd1;
      TYPE_ALU_OP: last_idx = 2'd3;
      default:     last_idx = 2'd1;
    endcase
  endfunction

  function automatic logic [BYTE_W-1:0] cmd_byte(input cmd_req_t req,
                                                 input logic [IDX_W-1:0] idx);
    logic [BYTE_W-1:0] b;
    b = '0;
    case (req.cmd_type)
      TYPE_WR:
        case (idx)
          2'd0:    b = CMD_WR;
          2'd1:    b = {4'b0, req.addr};
          2'd2:    b = req.data;
          default: b = '0;
        endcase
      TYPE_RD:
        case (idx)
          2'd0:    b = CMD_RD;
          2'd1:    b = {4'b0, req.addr};
          default: b = '0;
        endcase
      TYPE_ALU_OP:
        case (idx)
          2'd0:    b = CMD_ALU_OP;
          2'd1:    b = req.data;
          2'd2:    b = req.op_b;
          default: b = {4'b0, req.func};
        endcase
      default:
        case (idx)
          2'd0:    b = CMD_ALU_NOP;
          2'd1:    b = {4'b0, req.func};
          default: b = '0;
        endcase
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_cmd_frame_gen_if.sv
// Command request channel between a host driver and uart_cmd_frame_gen.
interface uart_cmd_frame_gen_if;
  import sys_cmd_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [TYPE_W-1:0] cmd_type;
  logic [ADDR_W-1:0] cmd_addr;
  logic [BYTE_W-1:0] cmd_data;
  logic [BYTE_W-1:0] cmd_op_b;
  logic [FUNC_W-1:0] cmd_func;
  logic              par_en;
  logic              par_typ;

  modport master (
    output cmd_valid, cmd_type, cmd_addr, cmd_data, cmd_op_b, cmd_func,
           par_en, par_typ,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_addr, cmd_data, cmd_op_b, cmd_func,
           par_en, par_typ,
    output cmd_ready
  );

endinterface

// File: rtl/uart_byte_ser.sv
// One-byte UART frame serializer: start, 8 data bits LSB first, optional
// parity, stop, then GAP_BITS idle bit periods.
module uart_byte_ser
  import sys_cmd_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned GAP_BITS     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [BYTE_W-1:0] byte_data,
  input  logic              par_en,
  input  logic              par_typ,
  output logic              bit_out,
  output logic              frame_end,
  output logic              idle_c
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned GAP_W  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  ser_state_e        state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [GAP_W-1:0]  gap_cnt;
  logic [BYTE_W-1:0] shift_q;
  logic              par_en_q;
  logic              par_bit_q;
  logic              bit_end_c;

  // frame_end marks the last cycle of the final bit so the next byte can
  // start on the following edge without an idle cycle.
  assign bit_end_c  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign frame_end  = bit_end_c &&
                      ((state == S_GAP && gap_cnt == GAP_W'(GAP_BITS - 1)) ||
                       (state == S_STOP && GAP_BITS == 0));
  assign idle_c     = (state == S_IDLE);
  assign byte_ready = idle_c || frame_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      gap_cnt   <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      bit_out   <= 1'b1;
    end else if (byte_valid && byte_ready) begin
      state     <= S_START;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      gap_cnt   <= '0;
      shift_q   <= byte_data;
      par_en_q  <= par_en;
      par_bit_q <= par_typ ? ~^byte_data : ^byte_data;
      bit_out   <= 1'b0;
    end else if (state != S_IDLE) begin
      if (!bit_end_c) begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end else begin
        baud_cnt <= '0;
        case (state)
          S_START: begin
            state   <= S_DATA;
            bit_idx <= '0;
            bit_out <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
          S_DATA: begin
            if (bit_idx == 3'd7) begin
              state   <= par_en_q ? S_PARITY : S_STOP;
              bit_out <= par_en_q ? par_bit_q : 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              bit_out <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
          S_PARITY: begin
            state   <= S_STOP;
            bit_out <= 1'b1;
          end
          S_STOP: begin
            state   <= (GAP_BITS == 0) ? S_IDLE : S_GAP;
            gap_cnt <= '0;
            bit_out <= 1'b1;
          end
          S_GAP: begin
            if (gap_cnt == GAP_W'(GAP_BITS - 1)) begin
              state <= S_IDLE;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
            bit_out <= 1'b1;
          end
          default: begin
            state   <= S_IDLE;
            bit_out <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_cmd_frame_gen.sv
// Host-side command serializer: expands one command into its SYS_CTRL byte
// sequence and sends each byte as a UART frame on TX_OUT.
module uart_cmd_frame_gen
  import sys_cmd_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned GAP_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_cmd_frame_gen_if.slave  cmd,
  output logic                 TX_OUT,
  output logic                 busy,
  output logic                 cmd_done
);

  cmd_req_t          req_in_c;
  cmd_req_t          req_q;
  logic [IDX_W-1:0]  byte_idx;
  logic              idle_c;
  logic              frame_end_c;
  logic              byte_ready_c;
  logic              accept_c;
  logic              last_c;
  logic              byte_valid_c;
  logic [BYTE_W-1:0] byte_c;
  logic              par_en_c;
  logic              par_typ_c;

  assign cmd.cmd_ready = idle_c && !rst;
  assign accept_c      = cmd.cmd_valid && cmd.cmd_ready;

  // Byte mux: the first byte comes straight from the request so the start
  // bit begins on the accept edge; later bytes come from the latched copy.
  always_comb begin
    req_in_c = '{cmd_type: cmd_type_e'(cmd.cmd_type),
                 addr:     cmd.cmd_addr,
                 data:     cmd.cmd_data,
                 op_b:     cmd.cmd_op_b,
                 func:     cmd.cmd_func,
                 par_en:   cmd.par_en,
                 par_typ:  cmd.par_typ};
    last_c       = (byte_idx == last_idx(req_q.cmd_type));
    byte_valid_c = accept_c;
    byte_c       = cmd_byte(req_in_c, '0);
    par_en_c     = req_in_c.par_en;
    par_typ_c    = req_in_c.par_typ;
    if (!idle_c) begin
      byte_valid_c = frame_end_c && !last_c;
      byte_c       = cmd_byte(req_q, byte_idx + IDX_W'(1));
      par_en_c     = req_q.par_en;
      par_typ_c    = req_q.par_typ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= '0;
      byte_idx <= '0;
      busy     <= 1'b0;
      cmd_done <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      if (accept_c) begin
        req_q    <= req_in_c;
        byte_idx <= '0;
        busy     <= 1'b1;
      end else if (!idle_c && frame_end_c) begin
        if (last_c) begin
          busy     <= 1'b0;
          cmd_done <= 1'b1;
        end else if (byte_ready_c) begin
          byte_idx <= byte_idx + IDX_W'(1);
        end
      end
    end
  end

  uart_byte_ser #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .GAP_BITS     (GAP_BITS)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid_c),
    .byte_ready (byte_ready_c),
    .byte_data  (byte_c),
    .par_en     (par_en_c),
    .par_typ    (par_typ_c),
    .bit_out    (TX_OUT),
    .frame_end  (frame_end_c),
    .idle_c     (idle_c)
  );

endmodule

// File: tb/tb_uart_cmd_frame_gen.sv
// Directed bench for uart_cmd_frame_gen: timing checks plus a line decoder
// that rebuilds each UART frame from TX_OUT.
module tb_uart_cmd_frame_gen;

  localparam int unsigned CPB = 4;

  logic clk;
  logic rst;
  logic tx_out;
  logic busy;
  logic cmd_done;

  uart_cmd_frame_gen_if cmd_bus ();

  uart_cmd_frame_gen #(
    .CLKS_PER_BIT (CPB),
    .GAP_BITS     (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd_bus.slave),
    .TX_OUT   (tx_out),
    .busy     (busy),
    .cmd_done (cmd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Decoded frame: {byte, parity, start, stop}
  logic [10:0] frames [$];
  logic        dec_par_en = 1'b0;
  logic [7:0]  eb [4];
  logic        ep [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Line decoder sampling mid-bit on the falling clock edge.
  initial begin : decoder
    bit         active;
    int         cnt;
    int         idx;
    logic [7:0] b;
    logic       p;
    logic       s;
    active = 1'b0;
    cnt = 0;
    b = '0;
    p = 1'b0;
    s = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx_out === 1'b0) begin
          active = 1'b1;
          cnt = 0;
          b = '0;
          p = 1'b0;
        end
      end else begin
        cnt++;
      end
      if (active && (cnt % CPB) == CPB / 2) begin
        idx = cnt / CPB;
        if (idx == 0) s = tx_out;
        else if (idx <= 8) b[idx-1] = tx_out;
        else if (idx == 9 && dec_par_en) p = tx_out;
        else begin
          frames.push_back({b, p, s, tx_out});
          active = 1'b0;
        end
      end
    end
  end

  task automatic wait_done(input int limit, input bit toggle, output int n, output int viol);
    n = 0;
    viol = 0;
    while (n <= limit) begin
      @(posedge clk); #1;
      n++;
      if (cmd_done) begin
        if (!(cmd_bus.cmd_ready && !busy)) viol++;
        break;
      end
      if (cmd_bus.cmd_ready || busy !== 1'b1) viol++;
      if (toggle && (n % 5) == 0) begin
        cmd_bus.par_en   = ~cmd_bus.par_en;
        cmd_bus.par_typ  = ~cmd_bus.par_typ;
        cmd_bus.cmd_data = cmd_bus.cmd_data ^ 8'hFF;
        cmd_bus.cmd_type = cmd_bus.cmd_type ^ 2'd1;
      end
    end
  endtask

  task automatic set_cmd(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                         input logic [7:0] ob, input logic [3:0] f, input logic pe, input logic pt);
    cmd_bus.cmd_type = t;
    cmd_bus.cmd_addr = a;
    cmd_bus.cmd_data = d;
    cmd_bus.cmd_op_b = ob;
    cmd_bus.cmd_func = f;
    cmd_bus.par_en   = pe;
    cmd_bus.par_typ  = pt;
  endtask

  task automatic send(input string tag, input logic [1:0] t, input logic [3:0] a,
                      input logic [7:0] d, input logic [7:0] ob, input logic [3:0] f,
                      input logic pe, input logic pt, input bit toggle, input int exp_len);
    int n;
    int viol;
    dec_par_en = pe;
    @(negedge clk); #1;
    set_cmd(t, a, d, ob, f, pe, pt);
    cmd_bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_start"}, 32'(tx_out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    cmd_bus.cmd_valid = 1'b0;
    wait_done(exp_len + 16, toggle, n, viol);
    chk({tag, "_len"}, n, exp_len);
    chk({tag, "_handshake"}, viol, 0);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(cmd_done), 32'd0);
  endtask

  task automatic check_frames(input string tag, input int n);
    logic [10:0] f;
    chk({tag, "_nframes"}, frames.size(), n);
    for (int i = 0; i < n; i++) begin
      if (frames.size() > 0) begin
        f = frames.pop_front();
        chk($sformatf("%s_frame%0d", tag, i), 32'(f), 32'({eb[i], ep[i], 2'b01}));
      end
    end
    frames.delete();
  endtask

  initial begin : stim
    int n;
    int viol;
    rst = 1'b1;
    cmd_bus.cmd_valid = 1'b0;
    set_cmd(2'd0, 4'd0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(cmd_done), 32'd0);
    chk("rst_ready_in_rst", 32'(cmd_bus.cmd_ready), 32'd0);
    @(negedge clk); #1 rst = 1'b0;
    #1;
    chk("rst_ready", 32'(cmd_bus.cmd_ready), 32'd1);

    // WR, even parity
    send("wr", 2'd0, 4'd2, 8'h55, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 144);
    eb = '{8'hAA, 8'h02, 8'h55, 8'h00};
    ep = '{1'b0, 1'b1, 1'b0, 1'b0};
    check_frames("wr", 3);

    // RD, no parity
    send("rd", 2'd1, 4'd3, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 88);
    eb = '{8'hBB, 8'h03, 8'h00, 8'h00};
    ep = '{1'b0, 1'b0, 1'b0, 1'b0};
    check_frames("rd", 2);

    // ALU_OP, odd parity
    send("aluop", 2'd2, 4'd0, 8'h0F, 8'h03, 4'd0, 1'b1, 1'b1, 1'b0, 192);
    eb = '{8'hCC, 8'h0F, 8'h03, 8'h00};
    ep = '{1'b1, 1'b1, 1'b1, 1'b1};
    check_frames("aluop", 4);

    // Back-to-back ALU_NOP with cmd_valid held
    dec_par_en = 1'b0;
    @(negedge clk); #1;
    set_cmd(2'd3, 4'd0, 8'h00, 8'h00, 4'h5, 1'b0, 1'b0);
    cmd_bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b_start0", 32'(tx_out), 32'd0);
    wait_done(120, 1'b0, n, viol);
    chk("b2b_len0", n, 88);
    chk("b2b_hs0", viol, 0);
    chk("b2b_gap_line", 32'(tx_out), 32'd1);
    cmd_bus.cmd_func = 4'hA;
    @(posedge clk); #1;
    chk("b2b_start1", 32'(tx_out), 32'd0);
    chk("b2b_busy1", 32'(busy), 32'd1);
    cmd_bus.cmd_valid = 1'b0;
    wait_done(120, 1'b0, n, viol);
    chk("b2b_len1", n, 88);
    chk("b2b_hs1", viol, 0);
    eb = '{8'hDD, 8'h05, 8'hDD, 8'h0A};
    ep = '{1'b0, 1'b0, 1'b0, 1'b0};
    check_frames("b2b", 4);

    // Reset mid-DATA of the third byte of a WR
    dec_par_en = 1'b1;
    @(negedge clk); #1;
    set_cmd(2'd0, 4'd4, 8'h3C, 8'h00, 4'd0, 1'b1, 1'b0);
    cmd_bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_bus.cmd_valid = 1'b0;
    repeat (109) @(posedge clk);
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_tx", 32'(tx_out), 32'd1);
    chk("mrst_busy", 32'(busy), 32'd0);
    @(negedge clk); #1 rst = 1'b0;
    #1;
    chk("mrst_ready", 32'(cmd_bus.cmd_ready), 32'd1);
    viol = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (cmd_done || tx_out !== 1'b1) viol++;
    end
    chk("mrst_quiet", viol, 0);
    eb = '{8'hAA, 8'h04, 8'h00, 8'h00};
    ep = '{1'b0, 1'b1, 1'b0, 1'b0};
    check_frames("mrst", 2);
    send("post_rst", 2'd1, 4'd7, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 88);
    eb = '{8'hBB, 8'h07, 8'h00, 8'h00};
    ep = '{1'b0, 1'b0, 1'b0, 1'b0};
    check_frames("post_rst", 2);

    // Config inputs toggled while a WR is in flight
    send("latch", 2'd0, 4'd9, 8'hC3, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 144);
    eb = '{8'hAA, 8'h09, 8'hC3, 8'h00};
    ep = '{1'b1, 1'b1, 1'b1, 1'b0};
    check_frames("latch", 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
